// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that shares one FIFO write port among NUM_REQ producers.
// Write data and enable are registered. FIFO wr_ack/wr_err are routed back to the producer that issued each beat.
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     wr_clk,
    input  logic                     clear,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_din,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       acc,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       req_err,
    output logic [WIDTH-1:0]         din,
    output logic                     wr_en,
    input  logic                     full,
    input  logic                     almost_full,
    input  logic                     wr_ack,
    input  logic                     wr_err,
    output logic                     busy
);

    localparam int unsigned IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNTW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     win_id;
    logic               win_found;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [WIDTH-1:0]   din_d;
    logic               wr_en_d;
    logic               stall;
    logic               acc_any;
    logic [WIDTH-1:0]   slot [NUM_REQ];
    logic               s1_vld, s2_vld;
    logic [IDW-1:0]     s1_id, s2_id;
    int unsigned        scan;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign slot[g] = req_din[g*WIDTH +: WIDTH];
    end

    // wr_en is one cycle behind acc, so almost_full only blocks when a beat is already in flight
    assign stall   = full | (almost_full & wr_en);
    assign acc_any = (state_q == BURST) & req[owner_q] & ~stall;

    always_comb begin
        acc          = '0;
        acc[owner_q] = acc_any;
    end

    // First active request at or after the round-robin pointer, wrapping
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan = (32'(ptr_q) + i) % NUM_REQ;
            if (!win_found && req[IDW'(scan)]) begin
                win_found = 1'b1;
                win_id    = IDW'(scan);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt;
        din_d   = din;
        wr_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BURST;
                    owner_d = win_id;
                    gnt_d   = NUM_REQ'(1) << win_id;
                    ptr_d   = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (acc_any) begin
                    wr_en_d = 1'b1;
                    din_d   = slot[owner_q];
                    cnt_d   = cnt_q + 1'b1;
                    if (req_last[owner_q] || (cnt_q == CNTW'(MAX_BURST - 1))) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wr_clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            din     <= '0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            din     <= din_d;
            wr_en   <= wr_en_d;
            busy    <= (state_d != IDLE);
        end
    end

    // Owner id follows each beat until the FIFO's response arrives two cycles after acc
    always_ff @(posedge wr_clk or posedge clear) begin
        if (clear) begin
            s1_vld  <= 1'b0;
            s1_id   <= '0;
            s2_vld  <= 1'b0;
            s2_id   <= '0;
            req_ack <= '0;
            req_err <= '0;
        end else begin
            s1_vld  <= acc_any;
            s1_id   <= owner_q;
            s2_vld  <= s1_vld;
            s2_id   <= s1_id;
            req_ack <= (s2_vld && wr_ack) ? (NUM_REQ'(1) << s2_id) : '0;
            req_err <= (s2_vld && wr_err) ? (NUM_REQ'(1) << s2_id) : '0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter. A transaction-level round-robin model predicts the write stream.
// A FIFO model supplies randomized responses and predicts the routed ack/err pulses.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 4;

    typedef struct {
        int                 cyc;
        logic [NUM_REQ-1:0] ack;
        logic [NUM_REQ-1:0] err;
    } ack_t;

    logic                     wr_clk = 1'b0;
    logic                     clear;
    logic [NUM_REQ-1:0]       req, req_last, gnt, acc, req_ack, req_err;
    logic [NUM_REQ*WIDTH-1:0] req_din;
    logic [WIDTH-1:0]         din;
    logic                     wr_en, full, almost_full, wr_ack, wr_err, busy;

    logic [WIDTH:0]     rq [NUM_REQ][$];
    logic [WIDTH-1:0]   exp_wr[$];
    int                 exp_own[$];
    ack_t               exp_ack[$];
    int                 vectors     = 0;
    int                 miscompares = 0;
    int                 cycle       = 0;
    int                 m_ptr       = 0;
    bit                 stall_en    = 1'b0;
    bit                 discard     = 1'b0;
    int                 full_hold   = 0;
    int                 seq [NUM_REQ];
    logic [NUM_REQ-1:0] acc_s   = '0;
    logic               wr_en_s = 1'b0;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .wr_clk(wr_clk), .clear(clear), .req(req), .req_din(req_din), .req_last(req_last),
        .gnt(gnt), .acc(acc), .req_ack(req_ack), .req_err(req_err), .din(din), .wr_en(wr_en),
        .full(full), .almost_full(almost_full), .wr_ack(wr_ack), .wr_err(wr_err), .busy(busy)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cycle);
        end
    endtask

    task automatic load(int i, logic [WIDTH-1:0] d, logic l);
        rq[i].push_back({l, d});
    endtask

    // n beats tagged with requester id; rnd gives random burst breaks and possible abandon
    task automatic load_n(int i, int n, bit rnd);
        logic l;
        for (int k = 0; k < n; k++) begin
            if (rnd) l = (k == n - 1) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            else     l = (k == n - 1);
            load(i, {2'(i), 6'(seq[i])}, l);
            seq[i]++;
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    // Round-robin over the queued beats; first >= 0 means that requester already holds the grant
    task automatic build_model(int first);
        logic [WIDTH:0] mq [NUM_REQ][$];
        logic [WIDTH:0] it;
        int  w, n, c;
        bit  go, done;
        for (int i = 0; i < NUM_REQ; i++) mq[i] = rq[i];
        go = 1'b1;
        while (go) begin
            w = -1;
            if (first >= 0) begin
                w     = first;
                first = -1;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (w < 0 && mq[c].size() > 0) w = c;
                end
            end
            if (w < 0) begin
                go = 1'b0;
            end else begin
                n    = 0;
                done = 1'b0;
                while (!done) begin
                    it = mq[w].pop_front();
                    n++;
                    exp_wr.push_back(it[WIDTH-1:0]);
                    exp_own.push_back(w);
                    done = it[WIDTH] || (n == MAX_BURST) || (mq[w].size() == 0);
                end
                m_ptr = (w + 1) % NUM_REQ;
            end
        end
    endtask

    task automatic wait_done(int budget);
        int t = 0;
        while ((pending() || exp_wr.size() > 0 || busy) && t < budget) begin
            @(negedge wr_clk);
            t++;
        end
        vectors++;
        if (t >= budget) begin
            miscompares++;
            $display("FAIL session_drain: %0d beats still expected after %0d cycles, required 0", exp_wr.size(), budget);
        end
        repeat (5) @(negedge wr_clk);
        check("ack_drained", 32'(exp_ack.size()), 32'(0));
        check("busy_idle", 32'(busy), 32'(0));
    endtask

    // Requester BFM and FIFO model, driven just after each rising edge
    initial begin
        logic [WIDTH:0]     h;
        logic [NUM_REQ-1:0] oh;
        ack_t               e;
        int                 r, o;
        req = '0; req_din = '0; req_last = '0;
        full = 1'b0; almost_full = 1'b0; wr_ack = 1'b0; wr_err = 1'b0;
        forever begin
            @(posedge wr_clk);
            #1;
            cycle++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_s[i] && rq[i].size() > 0) h = rq[i].pop_front();
                req[i] = (rq[i].size() > 0);
                if (rq[i].size() > 0) h = rq[i][0];
                else                  h = 9'($urandom);
                req_din[i*WIDTH +: WIDTH] = h[WIDTH-1:0];
                req_last[i]               = h[WIDTH];
            end
            if (wr_en_s) begin
                r      = $urandom_range(0, 7);
                wr_ack = (r >= 2);
                wr_err = (r == 1) || (r == 2);
                if (exp_own.size() > 0 && !discard) begin
                    o     = exp_own.pop_front();
                    oh    = '0;
                    oh[o] = 1'b1;
                    if (wr_ack || wr_err) begin
                        e.cyc = cycle + 1;
                        e.ack = wr_ack ? oh : '0;
                        e.err = wr_err ? oh : '0;
                        exp_ack.push_back(e);
                    end
                end
            end else begin
                wr_ack = ($urandom_range(0, 9) == 0);
                wr_err = ($urandom_range(0, 9) == 0);
            end
            if (stall_en) begin
                if (full_hold > 0) begin
                    full = 1'b1;
                    full_hold--;
                end else begin
                    full = ($urandom_range(0, 7) == 0);
                    if ($urandom_range(0, 39) == 0) full_hold = 5;
                end
                almost_full = ($urandom_range(0, 2) == 0);
            end else begin
                full        = 1'b0;
                almost_full = 1'b0;
            end
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT presents a beat or a response pulse
    initial begin
        ack_t e;
        forever begin
            @(negedge wr_clk);
            acc_s   = acc;
            wr_en_s = wr_en;
            if (!clear) begin
                check("gnt_onehot", 32'($onehot0(gnt)), 32'(1));
                check("acc_within_gnt", 32'(acc & ~gnt), 32'(0));
                if (full || (almost_full && wr_en)) check("acc_while_stalled", 32'(acc), 32'(0));
                if (wr_en) begin
                    if (exp_wr.size() == 0) check("din_unexpected_beat", 32'(din), 32'hFFFF_FFFF);
                    else                    check("din", 32'(din), 32'(exp_wr.pop_front()));
                end
                if (req_ack != '0 || req_err != '0) begin
                    if (exp_ack.size() == 0) begin
                        check("unexpected_ack_err", 32'({req_ack, req_err}), 32'(0));
                    end else begin
                        e = exp_ack.pop_front();
                        check("req_ack", 32'(req_ack), 32'(e.ack));
                        check("req_err", 32'(req_err), 32'(e.err));
                        check("ack_cycle", 32'(cycle), 32'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
        clear = 1'b1;
        repeat (2) @(negedge wr_clk);
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_wr_en", 32'(wr_en), 32'(0));
        check("rst_din", 32'(din), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ack_err", 32'({req_ack, req_err}), 32'(0));
        clear = 1'b0;
        @(negedge wr_clk);
        check("idle_gnt", 32'(gnt), 32'(0));

        // Single requester, three beats, one-cycle grant latency
        load(2, 8'hA1, 1'b0);
        load(2, 8'hA2, 1'b0);
        load(2, 8'hA3, 1'b1);
        build_model(-1);
        @(negedge wr_clk);
        check("gnt_before_arb", 32'(gnt), 32'(0));
        @(negedge wr_clk);
        check("gnt_latency", 32'(gnt), 32'(4'b0100));
        check("busy_granted", 32'(busy), 32'(1));
        wait_done(200);

        // Randomized sessions with stalls, burst breaks, MAX_BURST cutoffs and abandons
        stall_en = 1'b1;
        repeat (4) begin
            for (int i = 0; i < NUM_REQ; i++) load_n(i, $urandom_range(0, 10), 1'b1);
            build_model(-1);
            wait_done(4000);
        end

        // Reset while a beat is on the write port
        load_n(2, 6, 1'b0);
        build_model(-1);
        t = 0;
        while (!wr_en && t < 200) begin
            @(negedge wr_clk);
            t++;
        end
        check("beat_before_reset", 32'(wr_en), 32'(1));
        #2;
        discard = 1'b1;
        clear   = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        exp_wr.delete();
        exp_own.delete();
        exp_ack.delete();
        m_ptr = 0;
        #1;
        check("clr_wr_en", 32'(wr_en), 32'(0));
        check("clr_gnt", 32'(gnt), 32'(0));
        check("clr_busy", 32'(busy), 32'(0));
        repeat (2) @(negedge wr_clk);
        clear = 1'b0;
        repeat (6) begin
            @(negedge wr_clk);
            check("no_ack_after_reset", 32'({req_ack, req_err}), 32'(0));
        end
        discard = 1'b0;

        // Pointer restarts at requester 0: requester 1 must win over 3
        load_n(1, 3, 1'b0);
        load_n(3, 3, 1'b0);
        build_model(-1);
        wait_done(500);

        // Late requesters during requester 2's burst: 3 then 0, then 2 resumes
        load_n(2, 6, 1'b0);
        t = 0;
        while (gnt == '0 && t < 20) begin
            @(negedge wr_clk);
            t++;
        end
        check("late_first_gnt", 32'(gnt), 32'(4'b0100));
        load_n(0, 3, 1'b0);
        load_n(3, 3, 1'b0);
        build_model(2);
        wait_done(1000);

        for (int i = 0; i < NUM_REQ; i++) load_n(i, $urandom_range(1, 10), 1'b1);
        build_model(-1);
        wait_done(4000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
